// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: memory-controller request, decoder hand-off,
// branch-predictor next PC and reorder-buffer flush, as seen by inst_fetch.
interface inst_fetch_if #(
    parameter int AddressWidth = 32
);
    logic                    if_mc_en_out;
    logic [AddressWidth-1:0] if_mc_addr_out;
    logic                    mc_if_done_in;
    logic [31:0]             mc_if_data_in;

    logic                    if_decoder_en_out;
    logic [31:0]             if_decoder_inst_out;
    logic [AddressWidth-1:0] if_decoder_pc_out;
    logic                    decoder_if_stall_in;

    logic                    bp_if_en_in;
    logic [AddressWidth-1:0] bp_if_pc_in;

    logic                    rob_if_flush_in;
    logic [AddressWidth-1:0] rob_if_pc_in;

    modport master (
        output if_mc_en_out,
        output if_mc_addr_out,
        input  mc_if_done_in,
        input  mc_if_data_in,
        output if_decoder_en_out,
        output if_decoder_inst_out,
        output if_decoder_pc_out,
        input  decoder_if_stall_in,
        input  bp_if_en_in,
        input  bp_if_pc_in,
        input  rob_if_flush_in,
        input  rob_if_pc_in
    );

    modport slave (
        input  if_mc_en_out,
        input  if_mc_addr_out,
        output mc_if_done_in,
        output mc_if_data_in,
        input  if_decoder_en_out,
        input  if_decoder_inst_out,
        input  if_decoder_pc_out,
        output decoder_if_stall_in,
        output bp_if_en_in,
        output bp_if_pc_in,
        output rob_if_flush_in,
        output rob_if_pc_in
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the fetch PC, one outstanding memory read, one instruction to decode.
// Define ICACHE_EN to add a direct-mapped single-word-line I-cache in front of memory.
module inst_fetch #(
    parameter int AddressWidth      = 32,
    parameter int ICACHE_INDEX_BITS = 7
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    inst_fetch_if.master bus
);
    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        READY,
        DRAIN
    } state_t;

    state_t                  state_q, state_d;
    logic [AddressWidth-1:0] pc_q, pc_d;
    logic                    mc_en_q, mc_en_d;
    logic [AddressWidth-1:0] mc_addr_q, mc_addr_d;
    logic                    dec_en_q, dec_en_d;
    logic [31:0]             dec_inst_q, dec_inst_d;
    logic [AddressWidth-1:0] dec_pc_q, dec_pc_d;

    logic                    flush;
    logic                    issue;
    logic                    mc_done;
    logic                    hit;
    logic [31:0]             hit_data;

    assign flush   = bus.rob_if_flush_in;
    assign issue   = dec_en_q & ~bus.decoder_if_stall_in;
    assign mc_done = bus.mc_if_done_in;

`ifdef ICACHE_EN
    localparam int Lines  = 1 << ICACHE_INDEX_BITS;
    localparam int TagLsb = ICACHE_INDEX_BITS + 2;
    localparam int TagW   = AddressWidth - TagLsb;

    logic [Lines-1:0]             line_vld;
    logic [TagW-1:0]              line_tag  [Lines];
    logic [31:0]                  line_data [Lines];
    logic [ICACHE_INDEX_BITS-1:0] rd_idx;
    logic [ICACHE_INDEX_BITS-1:0] wr_idx;
    logic                         fill_we;

    // Lookup uses the fetch PC; fills use the address the memory request was issued for,
    // which differs from the PC once a flush has redirected fetch during DRAIN.
    assign rd_idx   = pc_q[TagLsb-1:2];
    assign wr_idx   = mc_addr_q[TagLsb-1:2];
    assign hit      = line_vld[rd_idx] && (line_tag[rd_idx] == pc_q[AddressWidth-1:TagLsb]);
    assign hit_data = line_data[rd_idx];
    assign fill_we  = mc_en_q & mc_done;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            line_vld <= '0;
        end else if (rdy_in && fill_we) begin
            line_vld[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rdy_in && fill_we) begin
            line_tag[wr_idx]  <= mc_addr_q[AddressWidth-1:TagLsb];
            line_data[wr_idx] <= bus.mc_if_data_in;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            mc_en_q    <= 1'b0;
            mc_addr_q  <= '0;
            dec_en_q   <= 1'b0;
            dec_inst_q <= '0;
            dec_pc_q   <= '0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mc_en_q    <= mc_en_d;
            mc_addr_q  <= mc_addr_d;
            dec_en_q   <= dec_en_d;
            dec_inst_q <= dec_inst_d;
            dec_pc_q   <= dec_pc_d;
        end
    end

    // Flush is checked first in every state; an in-flight memory read is never abandoned.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mc_en_d    = mc_en_q;
        mc_addr_d  = mc_addr_q;
        dec_en_d   = dec_en_q;
        dec_inst_d = dec_inst_q;
        dec_pc_d   = dec_pc_q;

        case (state_q)
            IDLE: begin
                if (flush) begin
                    pc_d = bus.rob_if_pc_in;
                end else if (hit) begin
                    state_d    = READY;
                    dec_en_d   = 1'b1;
                    dec_inst_d = hit_data;
                    dec_pc_d   = pc_q;
                end else begin
                    state_d   = FETCH;
                    mc_en_d   = 1'b1;
                    mc_addr_d = pc_q;
                end
            end

            FETCH: begin
                if (flush) begin
                    pc_d = bus.rob_if_pc_in;
                    if (mc_done) begin
                        mc_en_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (mc_done) begin
                    mc_en_d    = 1'b0;
                    dec_en_d   = 1'b1;
                    dec_inst_d = bus.mc_if_data_in;
                    dec_pc_d   = pc_q;
                    state_d    = READY;
                end
            end

            READY: begin
                if (flush) begin
                    pc_d     = bus.rob_if_pc_in;
                    dec_en_d = 1'b0;
                    state_d  = IDLE;
                end else if (issue) begin
                    pc_d     = bus.bp_if_en_in ? bus.bp_if_pc_in : pc_q + AddressWidth'(4);
                    dec_en_d = 1'b0;
                    state_d  = IDLE;
                end
            end

            DRAIN: begin
                if (flush) begin
                    pc_d = bus.rob_if_pc_in;
                end
                if (mc_done) begin
                    mc_en_d = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.if_mc_en_out        = mc_en_q;
    assign bus.if_mc_addr_out      = mc_addr_q;
    assign bus.if_decoder_en_out   = dec_en_q;
    assign bus.if_decoder_inst_out = dec_inst_q;
    assign bus.if_decoder_pc_out   = dec_pc_q;
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch stage of the Tomasulo RISC-V core. Holds the architectural fetch PC and obtains 32-bit instruction words from the memory controller, optionally through a small direct-mapped I-cache.
- Presents one instruction at a time to the decoder.
- Takes the next PC from the branch predictor in the same cycle an instruction is accepted. Takes a redirect PC from the reorder buffer on misprediction flush.

Parameters:
- AddressWidth, 32, PC and memory address width in bits.
- ICACHE_INDEX_BITS, 7, log2 of I-cache line count (128 lines of one word each). Used only when ICACHE_EN is defined.

Ports:
- clk_in  input  1  clock, rising edge
- rst_in  input  1  reset; asynchronous, active-high
- rdy_in  input  1  global enable; low freezes all state
- if_mc_en_out  output  1  memory read request, held until done
- if_mc_addr_out  output  AddressWidth  word address of request (PC)
- mc_if_done_in  input  1  request complete, data valid this cycle
- mc_if_data_in  input  32  instruction word
- if_decoder_en_out  output  1  instruction valid to decoder
- if_decoder_inst_out  output  32  instruction word
- if_decoder_pc_out  output  AddressWidth  PC of that instruction
- decoder_if_stall_in  input  1  downstream full; instruction not accepted
- bp_if_en_in  input  1  next PC supplied by predictor this cycle (branch/JAL decoded)
- bp_if_pc_in  input  AddressWidth  predicted next PC
- rob_if_flush_in  input  1  misprediction flush
- rob_if_pc_in  input  AddressWidth  correct restart PC

Behaviour:
- Reset (async): pc=0, state=IDLE, every output 0, all I-cache valid bits cleared.
- rdy_in=0: no state, pc or cache change; outputs hold; mc request stays asserted if already in FETCH/DRAIN.
- States:
  - IDLE: look up pc.
    - Hit -> READY next cycle, inst from cache.
    - Miss (or no cache) -> FETCH; if_mc_en_out=1, addr=pc from the next cycle.
  - FETCH: hold en and addr. On mc_if_done_in: latch data, fill cache line (valid, tag, data), -> READY.
  - READY: if_decoder_en_out=1, inst/pc outputs stable. Issue = en & !decoder_if_stall_in.
    - On issue: pc <= bp_if_en_in ? bp_if_pc_in : pc+4 (wraps modulo 2^AddressWidth); -> IDLE.
    - While stalled: outputs held unchanged.
  - DRAIN: entered on a flush while in FETCH. Hold en and addr until done. Fill cache with returned data, do not present it, -> IDLE. Memory requests are never aborted.
- Flush (rob_if_flush_in & rdy_in) has top priority in every state:
  - pc <= rob_if_pc_in.
  - if_decoder_en_out deasserts next cycle.
  - State -> IDLE, or -> DRAIN if in FETCH.
  - Flush in DRAIN: stay in DRAIN, pc updated.
  - Flush with simultaneous issue: flush wins, bp inputs ignored.
  - Flush in the same cycle as mc_if_done_in in FETCH: data goes to cache only; -> IDLE.
- Latency:
  - Hit: 1 cycle IDLE->READY, so one instruction per 2 cycles at best.
  - Miss: IDLE, then FETCH for N cycles until done, then READY.
- I-cache addressing:
  - index = pc[ICACHE_INDEX_BITS+1:2].
  - tag = pc[AddressWidth-1:ICACHE_INDEX_BITS+2].
  - pc[1:0] ignored; always 0 from well-formed inputs.
- No cache invalidation other than reset; self-modifying code is not supported.

Optional Feature:
- ICACHE_EN.
- Defined: direct-mapped I-cache of 2^ICACHE_INDEX_BITS single-word lines as described above.
- Undefined: no cache storage. IDLE always goes to FETCH, and the DRAIN fill is a no-op. Port list and handshakes are identical.

Test Plan:
- Reset mid-FETCH (rst_in pulsed between clock edges): outputs and pc go 0 immediately, without waiting for a clock edge. After release, first request has addr=0x0.
- Cold miss: pc=0x0, mc done after 3 cycles with 0x00500093 -> decoder sees en=1, inst=0x00500093, pc=0x0. Next request addr=0x4.
- Hit (ICACHE_EN): loop back to 0x0 via bp_if_en_in=1, bp_if_pc_in=0x0 -> no mc request; READY 1 cycle after IDLE with the same inst.
- Stall: hold decoder_if_stall_in=1 for 4 cycles in READY -> outputs unchanged, pc unchanged. Release -> single issue, pc=0x4.
- Flush during FETCH (addr 0x10), rob_if_pc_in=0x200 -> en/addr held until done, data never presented. Then request addr=0x200.
- rdy_in=0 for 3 cycles while READY with stall low -> no issue, pc unchanged. Resumes when rdy_in=1.
